ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-requester front end for the single-port CPU RAM: arbitrates an instruction-fetch read port and a data load/store port onto the RAM's single address/data/write-enable port, drives the RAM pins from registers, and routes read data back to the requester with a tag pipeline. It sits directly upstream of the RAM. The RAM registers its inputs and delivers read data two clocks after its pins are driven.

## Interface
- dataWidth, 32, width of data buses (must equal RAM data width)
- addrWidth, 32, width of address buses (must equal RAM address width)
- starveLimit, 4, consecutive lost arbitrations after which fetch wins; ≥1
- clka  in  1  single clock
- rsta  in  1  reset, asynchronous, active-high
- iReqValid  in  1  fetch request valid
- iReqAddr  in  addrWidth  fetch address
- iReqReady  out  1  fetch request accepted this cycle
- iRspValid  out  1  fetch read data valid (single-cycle pulse)
- iRspData  out  dataWidth  fetch read data
- dReqValid  in  1  data request valid
- dReqWe  in  1  1 = store, 0 = load
- dReqAddr  in  addrWidth  data address
- dReqData  in  dataWidth  store data
- dReqReady  out  1  data request accepted this cycle
- dRspValid  out  1  load data valid (single-cycle pulse; none for stores)
- dRspData  out  dataWidth  load data
- ramAddr  out  addrWidth  to RAM addra
- ramDin  out  dataWidth  to RAM dina
- ramWe  out  1  to RAM wea
- ramDout  in  dataWidth  from RAM douta

## Operation
- Handshake: a transfer occurs when valid && ready. Ready is combinational from both valids and the starve counter. Requesters must not make valid depend on ready. At most one grant per cycle; the other port sees ready=0.
- Priority: data wins by default. Fetch wins when dReqValid=0, or when starveCnt == starveLimit.
- starveCnt: resets to 0 on fetch grant or when iReqValid=0. Increments by 1 when iReqValid=1 and fetch is not granted. Saturates at starveLimit.
- On a grant, the winner's addr, data, and we are registered onto ramAddr, ramDin, and ramWe. A fetch grant drives ramWe=0 and ramDin=0.
- With no grant, ramWe=0 and ramAddr/ramDin hold their previous values.
- Tag pipeline: 3 stages, each stage {live, isFetch}. Stage 0 loads {grant && !we, fetchGranted}.
- When the stage 2 tag is live, pulse iRspValid if isFetch, else dRspValid.
- iRspData and dRspData are wired directly from ramDout. Their contents are meaningful only while the matching valid is high.
- Stores produce no response. Ordering is strict acceptance order on the single port, so a load accepted after a store to the same address returns the stored data.

## Timing
- Request accepted in cycle t → RAM pins driven in t+1 → response valid in cycle t+3. Fixed latency of 3, no stalls.
- Throughput: one request per cycle sustained, across either port.
- Responses have no backpressure; requesters always accept.
- Reset (rsta=1, asynchronous):
  - ramWe=0, ramAddr=0, ramDin=0.
  - All tag stages cleared, so iRspValid=0 and dRspValid=0.
  - starveCnt=0; iReqReady=0 and dReqReady=0 while rsta is high.
- Reset mid-operation: in-flight loads are dropped without a response. Any RAM write already registered inside the RAM may still complete; this is acceptable.
- First grant is possible in the first cycle after rsta deasserts.
- Simultaneous valid on both ports with starveCnt < starveLimit: data granted and starveCnt increments. With starveCnt == starveLimit: fetch granted and starveCnt returns to 0.

## Structure
- A shared package holds:
  - the tag struct {live, isFetch}
  - tag constants TAG_NONE, TAG_FETCH, TAG_LOAD
  - RSP_LATENCY=3
- Sub-module rsp_tag_pipe: parameterized-depth shift register of tags with async reset. It outputs the two response valids.
- Arbitration, the starve counter, and the RAM pin registers stay in the top module.

## Test plan
- Single fetch of addr 0x10 after RAM preloaded with 0xCAFE0010 at that address → iRspValid exactly 3 cycles after acceptance, iRspData=0xCAFE0010, dRspValid stays 0.
- Store 0xDEADBEEF to 0x20 in cycle t, then load 0x20 in t+1 → no response for the store; dRspValid at t+4 with dRspData=0xDEADBEEF.
- Both valid continuously, starveLimit=4 → grant pattern D,D,D,D,I repeating; starveCnt never exceeds 4; every load and fetch returns the correct data in order.
- Back-to-back loads to 0x0..0x7 with iReqValid=0 → one acceptance per cycle; eight consecutive dRspValid pulses carrying matching data.
- Assert rsta with two loads in flight → no response pulses afterwards; ramWe=0 immediately; readies 0 while reset is held; a normal fetch succeeds after release.
- Idle with neither valid asserted → ramWe held at 0, no responses, starveCnt stays 0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter and its response tag pipeline.
package ram_port_arbiter_pkg;

  typedef struct packed {
    logic live;
    logic isFetch;
  } rspTag_t;

  localparam rspTag_t TAG_NONE  = '{live: 1'b0, isFetch: 1'b0};
  localparam rspTag_t TAG_FETCH = '{live: 1'b1, isFetch: 1'b1};
  localparam rspTag_t TAG_LOAD  = '{live: 1'b1, isFetch: 1'b0};

  // One clock to register the RAM pins plus two clocks of RAM read latency.
  localparam int RSP_LATENCY = 3;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle: fetch read port and data load/store port with their responses.
interface ram_port_arbiter_if #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
);

  logic                 iReqValid;
  logic [addrWidth-1:0] iReqAddr;
  logic                 iReqReady;
  logic                 iRspValid;
  logic [dataWidth-1:0] iRspData;

  logic                 dReqValid;
  logic                 dReqWe;
  logic [addrWidth-1:0] dReqAddr;
  logic [dataWidth-1:0] dReqData;
  logic                 dReqReady;
  logic                 dRspValid;
  logic [dataWidth-1:0] dRspData;

  modport master (
    output iReqValid, iReqAddr, dReqValid, dReqWe, dReqAddr, dReqData,
    input  iReqReady, iRspValid, iRspData, dReqReady, dRspValid, dRspData
  );

  modport slave (
    input  iReqValid, iReqAddr, dReqValid, dReqWe, dReqAddr, dReqData,
    output iReqReady, iRspValid, iRspData, dReqReady, dRspValid, dRspData
  );

endinterface

// File: rtl/ram_port_arbiter_rsp_tag_pipe.sv
// Shift register of response tags that tracks which requester owns each RAM read in flight.
module rsp_tag_pipe
  import ram_port_arbiter_pkg::*;
#(
  parameter int depth = RSP_LATENCY
) (
  input  logic    clka,
  input  logic    rsta,
  input  rspTag_t tagIn,
  output logic    iRspValid,
  output logic    dRspValid
);

  rspTag_t stages [depth];

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      for (int i = 0; i < depth; i++) begin
        stages[i] <= TAG_NONE;
      end
    end else begin
      stages[0] <= tagIn;
      for (int i = 1; i < depth; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign iRspValid = stages[depth-1].live &&  stages[depth-1].isFetch;
  assign dRspValid = stages[depth-1].live && !stages[depth-1].isFetch;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates fetch and data requesters onto the single-port RAM and steers read data back.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int dataWidth   = 32,
  parameter int addrWidth   = 32,
  parameter int starveLimit = 4
) (
  input  logic                 clka,
  input  logic                 rsta,
  ram_port_arbiter_if.slave    bus,
  output logic [addrWidth-1:0] ramAddr,
  output logic [dataWidth-1:0] ramDin,
  output logic                 ramWe,
  input  logic [dataWidth-1:0] ramDout
);

  localparam int cntWidth = $clog2(starveLimit + 1);
  localparam logic [cntWidth-1:0] cntMax = cntWidth'(starveLimit);

  logic [cntWidth-1:0] starveCnt;
  logic                fetchWins;
  logic                iGrant;
  logic                dGrant;
  rspTag_t             tagIn;

  // Data has priority unless fetch has been starved for starveLimit cycles.
  always_comb begin
    fetchWins = bus.iReqValid && (!bus.dReqValid || starveCnt == cntMax);
    iGrant    = !rsta && fetchWins;
    dGrant    = !rsta && bus.dReqValid && !fetchWins;
    tagIn     = TAG_NONE;
    if (iGrant) begin
      tagIn = TAG_FETCH;
    end else if (dGrant && !bus.dReqWe) begin
      tagIn = TAG_LOAD;
    end
  end

  assign bus.iReqReady = iGrant;
  assign bus.dReqReady = dGrant;
  assign bus.iRspData  = ramDout;
  assign bus.dRspData  = ramDout;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      starveCnt <= '0;
    end else if (iGrant || !bus.iReqValid) begin
      starveCnt <= '0;
    end else if (starveCnt != cntMax) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Address and data hold when idle so the RAM sees no needless toggling.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ramAddr <= '0;
      ramDin  <= '0;
      ramWe   <= 1'b0;
    end else if (iGrant) begin
      ramAddr <= bus.iReqAddr;
      ramDin  <= '0;
      ramWe   <= 1'b0;
    end else if (dGrant) begin
      ramAddr <= bus.dReqAddr;
      ramDin  <= bus.dReqData;
      ramWe   <= bus.dReqWe;
    end else begin
      ramWe   <= 1'b0;
    end
  end

  rsp_tag_pipe #(
    .depth(RSP_LATENCY)
  ) tagPipe (
    .clka      (clka),
    .rsta      (rsta),
    .tagIn     (tagIn),
    .iRspValid (bus.iRspValid),
    .dRspValid (bus.dRspValid)
  );

endmodule
